// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard control bus between the pipeline datapath and pipe_hazard_ctrl.
// master = datapath side, slave = hazard controller side.
interface pipe_hazard_ctrl_if #(
    parameter int ADDR_LEFT = 4,
    parameter int CNT_BITS  = 16
);
    logic [ADDR_LEFT:0] id_rs_addr;
    logic [ADDR_LEFT:0] id_rt_addr;
    logic               id_uses_rs;
    logic               id_uses_rt;
    logic               ex_sel_mem;
    logic               ex_rw_;
    logic [ADDR_LEFT:0] ex_waddr;
    logic               branch_taken;
    logic               mem_stall;
    logic               halt_s2;
    logic               pc_en;
    logic               if_id_en;
    logic               id_ex_en;
    logic               ex_mem_en;
    logic               if_id_flush;
    logic               id_ex_bubble;
    logic               halted;
    logic [CNT_BITS-1:0] stall_cycles;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
        output ex_sel_mem, ex_rw_, ex_waddr,
        output branch_taken, mem_stall, halt_s2,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en,
        input  if_id_flush, id_ex_bubble, halted, stall_cycles
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
        input  ex_sel_mem, ex_rw_, ex_waddr,
        input  branch_taken, mem_stall, halt_s2,
        output pc_en, if_id_en, id_ex_en, ex_mem_en,
        output if_id_flush, id_ex_bubble, halted, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze,
// HALT drain sequence and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int ADDR_LEFT    = 4,
    parameter int CNT_BITS     = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t              r_state;
    logic [DW-1:0]       r_drain;
    logic [CNT_BITS-1:0] r_stall;

    logic w_load_use;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_stall_inc;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_id_ex_en;
    logic w_ex_mem_en;
    logic w_flush;
    logic w_bubble;

    assign w_rs_hit = bus.id_uses_rs && (bus.id_rs_addr == bus.ex_waddr);
    assign w_rt_hit = bus.id_uses_rt && (bus.id_rt_addr == bus.ex_waddr);
    assign w_load_use = bus.ex_sel_mem && !bus.ex_rw_ &&
                        (bus.ex_waddr != '0) && (w_rs_hit || w_rt_hit);

    assign w_stall_inc = (r_state != HALTED) &&
                         (bus.mem_stall ||
                          ((r_state == RUN) && w_load_use &&
                           !bus.branch_taken));

    // Enables, flush and bubble decoded from state and current hazards.
    always_comb begin
        w_pc_en     = 1'b0;
        w_if_id_en  = 1'b0;
        w_id_ex_en  = 1'b0;
        w_ex_mem_en = 1'b0;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        unique case (r_state)
            RUN: begin
                if (bus.mem_stall) begin
                    w_pc_en = 1'b0;
                end else if (bus.branch_taken) begin
                    w_pc_en     = 1'b1;
                    w_if_id_en  = 1'b1;
                    w_id_ex_en  = 1'b1;
                    w_ex_mem_en = 1'b1;
                    w_flush     = 1'b1;
                    w_bubble    = 1'b1;
                end else if (w_load_use) begin
                    w_id_ex_en  = 1'b1;
                    w_ex_mem_en = 1'b1;
                    w_bubble    = 1'b1;
                end else begin
                    w_pc_en     = 1'b1;
                    w_if_id_en  = 1'b1;
                    w_id_ex_en  = 1'b1;
                    w_ex_mem_en = 1'b1;
                end
            end
            DRAIN: begin
                if (!bus.mem_stall) begin
                    w_id_ex_en  = 1'b1;
                    w_ex_mem_en = 1'b1;
                    w_bubble    = 1'b1;
                end
            end
            HALTED: begin
                w_pc_en = 1'b0;
            end
            default: begin
                w_pc_en = 1'b0;
            end
        endcase
    end

    // Run/drain/halted sequencing; drain counts only non-stalled cycles.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= RUN;
            r_drain <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (!bus.mem_stall && !bus.branch_taken &&
                        !w_load_use && bus.halt_s2) begin
                        r_state <= DRAIN;
                        r_drain <= DW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (!bus.mem_stall) begin
                        r_drain <= r_drain - 1'b1;
                        if (r_drain <= DW'(1)) begin
                            r_state <= HALTED;
                            r_drain <= '0;
                        end
                    end
                end
                HALTED: r_state <= HALTED;
                default: r_state <= RUN;
            endcase
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_stall <= '0;
        end else if (w_stall_inc && (r_stall != {CNT_BITS{1'b1}})) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.if_id_en     = w_if_id_en;
    assign bus.id_ex_en     = w_id_ex_en;
    assign bus.ex_mem_en    = w_ex_mem_en;
    assign bus.if_id_flush  = w_flush;
    assign bus.id_ex_bubble = w_bubble;
    assign bus.halted       = (r_state == HALTED);
    assign bus.stall_cycles = r_stall;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random stimulus
// against a rule-level reference model.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 running, 1 draining, 2 stopped.
    int m_phase = 0;
    int m_drain = 0;
    int m_stall = 0;

    localparam logic [5:0] EN_ALL = 6'b111100;
    localparam logic [5:0] EN_BR  = 6'b111111;
    localparam logic [5:0] EN_LU  = 6'b001101;
    localparam logic [5:0] EN_OFF = 6'b000000;

    pipe_hazard_ctrl_if #(.ADDR_LEFT(4), .CNT_BITS(16)) bus ();

    pipe_hazard_ctrl #(
        .ADDR_LEFT(4),
        .CNT_BITS(16),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk (clk),
        .rst_(rst_),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] en_vec();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                bus.if_id_flush, bus.id_ex_bubble};
    endfunction

    task automatic quiet();
        bus.id_rs_addr   = '0;
        bus.id_rt_addr   = '0;
        bus.id_uses_rs   = 1'b0;
        bus.id_uses_rt   = 1'b0;
        bus.ex_sel_mem   = 1'b0;
        bus.ex_rw_       = 1'b1;
        bus.ex_waddr     = '0;
        bus.branch_taken = 1'b0;
        bus.mem_stall    = 1'b0;
        bus.halt_s2      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        quiet();
        rst_ = 1'b0;
        m_phase = 0;
        m_drain = 0;
        m_stall = 0;
        #2;
        rst_ = 1'b1;
    endtask

    task automatic test_reset();
        quiet();
        rst_ = 1'b0;
        #12;
        checks++;
        if (en_vec() !== EN_ALL) begin
            failures++;
            $display("FAIL reset_en got=%b exp=%b", en_vec(), EN_ALL);
        end
        checks++;
        if (bus.halted !== 1'b0 || bus.stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL reset_state halted=%b stall=%0d exp 0/0",
                     bus.halted, bus.stall_cycles);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        bus.ex_sel_mem = 1'b1;
        bus.ex_rw_     = 1'b0;
        bus.ex_waddr   = 5'd5;
        bus.id_uses_rt = 1'b1;
        bus.id_rt_addr = 5'd5;
        #1;
        checks++;
        if (en_vec() !== EN_LU) begin
            failures++;
            $display("FAIL load_use_en got=%b exp=%b", en_vec(), EN_LU);
        end
        @(posedge clk);
        @(negedge clk);
        quiet();
        #1;
        checks++;
        if (bus.stall_cycles !== 16'd1 || en_vec() !== EN_ALL) begin
            failures++;
            $display("FAIL load_use_after stall=%0d en=%b exp 1/%b",
                     bus.stall_cycles, en_vec(), EN_ALL);
        end
    endtask

    task automatic test_load_r0();
        do_reset();
        @(negedge clk);
        bus.ex_sel_mem = 1'b1;
        bus.ex_rw_     = 1'b0;
        bus.ex_waddr   = 5'd0;
        bus.id_uses_rt = 1'b1;
        bus.id_rt_addr = 5'd0;
        bus.id_uses_rs = 1'b1;
        #1;
        checks++;
        if (en_vec() !== EN_ALL) begin
            failures++;
            $display("FAIL load_r0_en got=%b exp=%b", en_vec(), EN_ALL);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL load_r0_stall got=%0d exp=0", bus.stall_cycles);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        @(negedge clk);
        bus.ex_sel_mem   = 1'b1;
        bus.ex_rw_       = 1'b0;
        bus.ex_waddr     = 5'd7;
        bus.id_uses_rs   = 1'b1;
        bus.id_rs_addr   = 5'd7;
        bus.halt_s2      = 1'b1;
        bus.branch_taken = 1'b1;
        #1;
        checks++;
        if (en_vec() !== EN_BR) begin
            failures++;
            $display("FAIL branch_en got=%b exp=%b", en_vec(), EN_BR);
        end
        @(posedge clk);
        @(negedge clk);
        quiet();
        #1;
        checks++;
        if (en_vec() !== EN_ALL || bus.stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL branch_after en=%b stall=%0d exp %b/0",
                     en_vec(), bus.stall_cycles, EN_ALL);
        end
    endtask

    task automatic test_halt_drain();
        logic ms [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        @(negedge clk);
        bus.halt_s2 = 1'b1;
        #1;
        checks++;
        if (en_vec() !== EN_ALL) begin
            failures++;
            $display("FAIL halt_entry_en got=%b exp=%b", en_vec(), EN_ALL);
        end
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            quiet();
            bus.halt_s2   = 1'b1;
            bus.mem_stall = ms[k];
            #1;
            checks++;
            if (bus.halted !== 1'b0 ||
                en_vec() !== (ms[k] ? EN_OFF : EN_LU)) begin
                failures++;
                $display("FAIL drain_step%0d halted=%b en=%b", k,
                         bus.halted, en_vec());
            end
            @(posedge clk);
        end
        @(negedge clk);
        quiet();
        #1;
        checks++;
        if (bus.halted !== 1'b1 || en_vec() !== EN_OFF ||
            bus.stall_cycles !== 16'd2) begin
            failures++;
            $display("FAIL halted_state halted=%b en=%b stall=%0d exp 1/0/2",
                     bus.halted, en_vec(), bus.stall_cycles);
        end
        bus.mem_stall = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.stall_cycles !== 16'd2 || bus.halted !== 1'b1) begin
            failures++;
            $display("FAIL halted_ignore_stall stall=%0d halted=%b exp 2/1",
                     bus.stall_cycles, bus.halted);
        end
    endtask

    task automatic test_reset_in_halted();
        do_reset();
        @(negedge clk);
        bus.mem_stall = 1'b1;
        @(negedge clk);
        bus.mem_stall = 1'b0;
        bus.halt_s2   = 1'b1;
        @(negedge clk);
        quiet();
        @(negedge clk);
        #2;
        rst_ = 1'b0;
        #1;
        rst_ = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.halted !== 1'b0 || en_vec() !== EN_ALL) begin
            failures++;
            $display("FAIL reset_mid_drain halted=%b en=%b exp 0/%b",
                     bus.halted, en_vec(), EN_ALL);
        end
        bus.mem_stall = 1'b1;
        @(negedge clk);
        bus.mem_stall = 1'b0;
        bus.halt_s2   = 1'b1;
        @(negedge clk);
        quiet();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.halted !== 1'b1 || bus.stall_cycles !== 16'd1) begin
            failures++;
            $display("FAIL pre_reset_halted halted=%b stall=%0d exp 1/1",
                     bus.halted, bus.stall_cycles);
        end
        #3;
        rst_ = 1'b0;
        #1;
        checks++;
        if (bus.halted !== 1'b0 || bus.stall_cycles !== 16'd0 ||
            bus.pc_en !== 1'b1) begin
            failures++;
            $display("FAIL async_reset halted=%b stall=%0d pc_en=%b exp 0/0/1",
                     bus.halted, bus.stall_cycles, bus.pc_en);
        end
        #1;
        rst_ = 1'b1;
    endtask

    task automatic test_random();
        int hcnt;
        logic lu;
        logic [5:0] exp_en;
        hcnt = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.id_rs_addr   = 5'($urandom_range(0, 3));
            bus.id_rt_addr   = 5'($urandom_range(0, 3));
            bus.id_uses_rs   = 1'($urandom_range(0, 1));
            bus.id_uses_rt   = 1'($urandom_range(0, 1));
            bus.ex_sel_mem   = 1'($urandom_range(0, 1));
            bus.ex_rw_       = 1'($urandom_range(0, 1));
            bus.ex_waddr     = 5'($urandom_range(0, 3));
            bus.mem_stall    = ($urandom_range(0, 3) == 0);
            bus.branch_taken = ($urandom_range(0, 4) == 0);
            bus.halt_s2      = ($urandom_range(0, 11) == 0);
            lu = bus.ex_sel_mem && !bus.ex_rw_ && bus.ex_waddr != 0 &&
                 ((bus.id_uses_rs && bus.id_rs_addr == bus.ex_waddr) ||
                  (bus.id_uses_rt && bus.id_rt_addr == bus.ex_waddr));
            if (m_phase == 2 || bus.mem_stall) exp_en = EN_OFF;
            else if (m_phase == 1) exp_en = EN_LU;
            else if (bus.branch_taken) exp_en = EN_BR;
            else if (lu) exp_en = EN_LU;
            else exp_en = EN_ALL;
            #1;
            checks++;
            if (en_vec() !== exp_en) begin
                failures++;
                $display("FAIL rand_en cyc=%0d got=%b exp=%b",
                         i, en_vec(), exp_en);
            end
            checks++;
            if (bus.halted !== (m_phase == 2) ||
                bus.stall_cycles !== 16'(m_stall)) begin
                failures++;
                $display("FAIL rand_state cyc=%0d halted=%b stall=%0d exp %0d/%0d",
                         i, bus.halted, bus.stall_cycles,
                         m_phase == 2, m_stall);
            end
            @(posedge clk);
            if (m_phase != 2) begin
                if (bus.mem_stall || (m_phase == 0 && lu && !bus.branch_taken))
                    m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
                if (!bus.mem_stall) begin
                    if (m_phase == 0) begin
                        if (!bus.branch_taken && !lu && bus.halt_s2) begin
                            m_phase = 1;
                            m_drain = 3;
                        end
                    end else begin
                        m_drain--;
                        if (m_drain == 0) m_phase = 2;
                    end
                end
            end
            if (m_phase == 2) hcnt++;
            if (hcnt == 4) begin
                #2;
                rst_ = 1'b0;
                m_phase = 0;
                m_drain = 0;
                m_stall = 0;
                #1;
                rst_ = 1'b1;
                hcnt = 0;
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        bus.mem_stall = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (bus.stall_cycles !== 16'd65534) begin
            failures++;
            $display("FAIL sat_near got=%0d exp=65534", bus.stall_cycles);
        end
        repeat (600) @(posedge clk);
        #1;
        checks++;
        if (bus.stall_cycles !== 16'd65535) begin
            failures++;
            $display("FAIL sat_hold got=%0d exp=65535", bus.stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_r0();
        test_branch_priority();
        test_halt_drain();
        test_reset_in_halted();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
